// File: rtl/led_display_ram_ctrl_if.sv
// Frame RAM read port and row-pair handshake toward the LED driver PHY.
interface led_display_ram_ctrl_if;
    logic [12:0]  ram_address_out;
    logic [63:0]  ram_rdata_in;
    logic [383:0] row_out;
    logic         row_valid_out;
    logic [3:0]   row_address_out;
    logic         row_ready_in;

    modport master (
        output ram_address_out,
        output row_out,
        output row_valid_out,
        output row_address_out,
        input  ram_rdata_in,
        input  row_ready_in
    );

    modport slave (
        input  ram_address_out,
        input  row_out,
        input  row_valid_out,
        input  row_address_out,
        output ram_rdata_in,
        output row_ready_in
    );
endinterface

// File: rtl/led_display_ram_ctrl.sv
// Frame-buffer reader for a 64x32 1/16-scan RGB panel: fetches one
// row-pair (r, r+16) per scan line and offers it to the PHY.
module led_display_ram_ctrl #(
    parameter int          RAM_LATENCY    = 2,
    parameter logic [12:0] BASE_ADDR      = 13'd0,
    parameter int          NUM_ROW_PIXELS = 32,
    parameter int          NUM_COL_PIXELS = 64
) (
    input logic                    clk_in,
    input logic                    reset_in,
    led_display_ram_ctrl_if.master bus
);

    typedef enum logic [1:0] {FETCH, WAIT, VALID} state_e;

    localparam logic [3:0] LAT       = 4'(RAM_LATENCY);
    localparam logic [3:0] DONE      = LAT + 4'd5;
    localparam logic [3:0] LAST_SCAN = 4'(NUM_ROW_PIXELS / 2 - 1);

    state_e                          state_q, state_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic [3:0]                      scan_q, scan_d;
    logic [12:0]                     addr_q, addr_d;
    logic [5:0][NUM_COL_PIXELS-1:0]  buf_q, buf_d;
    logic [383:0]                    row_q, row_d;
    logic                            valid_q, valid_d;
    logic [2:0]                      idx;

    // Word k: k<3 top row, k>=3 bottom row; channel is k mod 3.
    function automatic logic [12:0] addr_of(input logic [3:0] r,
                                            input logic [2:0] k);
        logic       bot;
        logic [1:0] ch;
        bot = (k >= 3'd3);
        ch  = bot ? 2'(k - 3'd3) : k[1:0];
        return BASE_ADDR + {6'd0, bot, r, ch};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scan_d  = scan_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        row_d   = row_q;
        valid_d = valid_q;
        idx     = 3'(cnt_q - LAT);
        unique case (state_q)
            FETCH, WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q >= LAT) begin
                    buf_d[idx] = bus.ram_rdata_in;
                end
                if (state_q == FETCH) begin
                    if (cnt_q < 4'd5) begin
                        addr_d = addr_of(scan_q, cnt_q[2:0] + 3'd1);
                    end else begin
                        state_d = WAIT;
                    end
                end
                // Publish only once the sixth word has landed.
                if (cnt_q == DONE) begin
                    row_d   = buf_d;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.row_ready_in) begin
                    valid_d = 1'b0;
                    scan_d  = (scan_q == LAST_SCAN) ? 4'd0 : scan_q + 4'd1;
                    addr_d  = addr_of(scan_d, 3'd0);
                    cnt_d   = 4'd0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        buf_q <= buf_d;
        if (reset_in) begin
            state_q <= FETCH;
            cnt_q   <= 4'd0;
            scan_q  <= 4'd0;
            addr_q  <= BASE_ADDR;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ram_address_out = addr_q;
    assign bus.row_out         = row_q;
    assign bus.row_valid_out   = valid_q;
    assign bus.row_address_out = scan_q;

endmodule

// File: tb/tb_led_display_ram_ctrl.sv
// Directed bench: two controllers (base 0 / latency 2, base 128 / latency 3)
// reading a shared frame memory through latency pipes.
module tb_led_display_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [63:0] mem [0:8191];
    logic [63:0] p0 [0:1];
    logic [63:0] p1 [0:2];

    led_display_ram_ctrl_if if0();
    led_display_ram_ctrl_if if1();

    led_display_ram_ctrl #(
        .RAM_LATENCY(2), .BASE_ADDR(13'd0),
        .NUM_ROW_PIXELS(32), .NUM_COL_PIXELS(64)
    ) dut0 (.clk_in(clk), .reset_in(rst0), .bus(if0));

    led_display_ram_ctrl #(
        .RAM_LATENCY(3), .BASE_ADDR(13'd128),
        .NUM_ROW_PIXELS(32), .NUM_COL_PIXELS(64)
    ) dut1 (.clk_in(clk), .reset_in(rst1), .bus(if1));

    always @(posedge clk) begin
        p0[0] <= mem[if0.ram_address_out];
        p0[1] <= p0[0];
        p1[0] <= mem[if1.ram_address_out];
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end

    assign if0.ram_rdata_in = p0[1];
    assign if1.ram_rdata_in = p1[2];

    function automatic logic [12:0] ea(input int base, input int r,
                                       input int k);
        return 13'(base + (k >= 3 ? 64 : 0) + r * 4 + (k % 3));
    endfunction

    function automatic logic [383:0] er(input int base, input int r);
        logic [383:0] v;
        for (int k = 0; k < 6; k++) v[k*64 +: 64] = mem[ea(base, r, k)];
        return v;
    endfunction

    function automatic logic [12:0] o_addr(input int d);
        return d != 0 ? if1.ram_address_out : if0.ram_address_out;
    endfunction
    function automatic logic o_valid(input int d);
        return d != 0 ? if1.row_valid_out : if0.row_valid_out;
    endfunction
    function automatic logic [3:0] o_raddr(input int d);
        return d != 0 ? if1.row_address_out : if0.row_address_out;
    endfunction
    function automatic logic [383:0] o_row(input int d);
        return d != 0 ? if1.row_out : if0.row_out;
    endfunction

    task automatic chk(input string tag, input logic [383:0] obs,
                       input logic [383:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge with valid high and ready high: transfer,
    // then follow the fetch of row r and its exact valid latency.
    task automatic do_row(input int d, input int r);
        int base;
        int lat;
        base = d != 0 ? 128 : 0;
        lat  = d != 0 ? 3 : 2;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            chk($sformatf("d%0d_r%0d_addr%0d", d, r, k),
                384'(o_addr(d)), 384'(ea(base, r, k)));
            if (k == 0) begin
                chk($sformatf("d%0d_r%0d_vlow", d, r),
                    384'(o_valid(d)), 384'(1'b0));
                chk($sformatf("d%0d_r%0d_raddr0", d, r),
                    384'(o_raddr(d)), 384'(r));
            end
        end
        for (int j = 6; j <= 6 + lat; j++) begin
            step();
            chk($sformatf("d%0d_r%0d_valid_t%0d", d, r, j),
                384'(o_valid(d)), 384'(j == 6 + lat));
        end
        chk($sformatf("d%0d_r%0d_raddr", d, r), 384'(o_raddr(d)), 384'(r));
        chk($sformatf("d%0d_r%0d_row", d, r), o_row(d), er(base, r));
        chk($sformatf("d%0d_r%0d_addr_hold", d, r),
            384'(o_addr(d)), 384'(ea(base, r, 5)));
    endtask

    initial begin
        logic [383:0] held;
        for (int i = 0; i < 8192; i++) begin
            mem[i] = {3'b0, 13'(i), 16'hC3A5, 3'b0, 13'(i) ^ 13'h1FFF, 16'h0F0F};
        end
        mem[1]  = 64'hA5A5_0000_FFFF_0001;
        mem[66] = 64'h8000_0000_0000_0001;
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.row_ready_in = 1'b0;
        if1.row_ready_in = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid0", 384'(if0.row_valid_out), 384'(1'b0));
        chk("rst_raddr0", 384'(if0.row_address_out), 384'(4'd0));
        chk("rst_row0", if0.row_out, 384'd0);
        chk("rst_addr0", 384'(if0.ram_address_out), 384'(13'd0));
        chk("rst_valid1", 384'(if1.row_valid_out), 384'(1'b0));
        chk("rst_addr1", 384'(if1.ram_address_out), 384'(13'd128));
        chk("rst_row1", if1.row_out, 384'd0);

        rst0 = 1'b0;
        rst1 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("rel_addr0_%0d", i), 384'(if0.ram_address_out),
                384'(ea(0, 0, i < 5 ? i : 5)));
            chk($sformatf("rel_valid0_%0d", i), 384'(if0.row_valid_out),
                384'(i >= 8));
            chk($sformatf("rel_addr1_%0d", i), 384'(if1.ram_address_out),
                384'(ea(128, 0, i < 5 ? i : 5)));
            chk($sformatf("rel_valid1_%0d", i), 384'(if1.row_valid_out),
                384'(i >= 9));
        end
        chk("first_raddr0", 384'(if0.row_address_out), 384'(4'd0));
        chk("green_top", 384'(if0.row_out[127:64]),
            384'(64'hA5A5_0000_FFFF_0001));
        chk("blue_bot", 384'(if0.row_out[383:320]),
            384'(64'h8000_0000_0000_0001));
        chk("first_row0", if0.row_out, er(0, 0));
        chk("first_row1", if1.row_out, er(128, 0));

        held = er(0, 0);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("hold_valid", 384'(if0.row_valid_out), 384'(1'b1));
            chk("hold_row", if0.row_out, held);
            chk("hold_raddr", 384'(if0.row_address_out), 384'(4'd0));
            chk("hold_addr", 384'(if0.ram_address_out), 384'(13'd66));
        end

        if0.row_ready_in = 1'b1;
        for (int t = 1; t <= 16; t++) do_row(0, t % 16);
        for (int t = 1; t <= 4; t++) do_row(0, t);

        @(posedge clk);
        @(negedge clk);
        chk("mid_addr20", 384'(if0.ram_address_out), 384'(13'd20));
        step();
        chk("mid_addr21", 384'(if0.ram_address_out), 384'(13'd21));
        rst0 = 1'b1;
        step();
        chk("mid_rst_valid", 384'(if0.row_valid_out), 384'(1'b0));
        chk("mid_rst_raddr", 384'(if0.row_address_out), 384'(4'd0));
        chk("mid_rst_addr", 384'(if0.ram_address_out), 384'(13'd0));
        chk("mid_rst_row", if0.row_out, 384'd0);
        rst0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("re_addr0_%0d", i), 384'(if0.ram_address_out),
                384'(ea(0, 0, i < 5 ? i : 5)));
            chk($sformatf("re_valid0_%0d", i), 384'(if0.row_valid_out),
                384'(i == 8));
        end
        chk("re_row0", if0.row_out, er(0, 0));
        if0.row_ready_in = 1'b0;

        chk("d1_hold_valid", 384'(if1.row_valid_out), 384'(1'b1));
        chk("d1_hold_row", if1.row_out, er(128, 0));
        if1.row_ready_in = 1'b1;
        for (int t = 1; t <= 3; t++) do_row(1, t);

        if1.row_ready_in = 1'b0;
        rst1 = 1'b1;
        step();
        chk("v_rst_valid1", 384'(if1.row_valid_out), 384'(1'b0));
        chk("v_rst_raddr1", 384'(if1.row_address_out), 384'(4'd0));
        chk("v_rst_addr1", 384'(if1.ram_address_out), 384'(13'd128));
        chk("v_rst_row1", if1.row_out, 384'd0);
        rst1 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("re_valid1_%0d", i), 384'(if1.row_valid_out),
                384'(i == 9));
        end
        chk("re_row1", if1.row_out, er(128, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
